// File: rtl/calc1_port_arbiter.sv
// calc1_port_arbiter
// Round-robin scheduler in front of one calc1 ALU port. Each requester slot
// captures a two-cycle cmd/op1, op2 request and holds it until the arbiter
// has driven it to the ALU and returned the ALU's answer to that slot.
// Optional ALU-response watchdog: define CALC1_ARB_TIMEOUT_EN.

// One requester slot: capture cmd/op1, then op2, then hold until served.
module calc1_arb_slot (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  cmd_in,
    input  logic [31:0] data_in,
    input  logic        done,
    output logic        busy,
    output logic        pend,
    output logic [3:0]  cmd,
    output logic [31:0] op1,
    output logic [31:0] op2
);
    typedef enum logic [1:0] {S_IDLE, S_OP2, S_PEND} slot_st_t;

    slot_st_t    st_q, st_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;

    // Next-state: commands arriving while not idle are simply not looked at.
    always_comb begin
        st_d  = st_q;
        cmd_d = cmd_q;
        op1_d = op1_q;
        op2_d = op2_q;
        case (st_q)
            S_IDLE: begin
                if (cmd_in != 4'b0000) begin
                    cmd_d = cmd_in;
                    op1_d = data_in;
                    st_d  = S_OP2;
                end
            end
            S_OP2: begin
                op2_d = data_in;
                st_d  = S_PEND;
            end
            S_PEND: begin
                if (done) st_d = S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end

    // Slot state and operand registers.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            st_q  <= S_IDLE;
            cmd_q <= 4'b0000;
            op1_q <= 32'd0;
            op2_q <= 32'd0;
        end else begin
            st_q  <= st_d;
            cmd_q <= cmd_d;
            op1_q <= op1_d;
            op2_q <= op2_d;
        end
    end

    assign busy = (st_q != S_IDLE);
    assign pend = (st_q == S_PEND);
    assign cmd  = cmd_q;
    assign op1  = op1_q;
    assign op2  = op2_q;
endmodule

module calc1_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  c_clk,
    input  logic                  reset,
    input  logic [4*NUM_REQ-1:0]  req_cmd_in,
    input  logic [32*NUM_REQ-1:0] req_data_in,
    output logic [2*NUM_REQ-1:0]  out_resp,
    output logic [32*NUM_REQ-1:0] out_data,
    output logic [NUM_REQ-1:0]    req_busy,
    output logic [3:0]            alu_cmd_out,
    output logic [31:0]           alu_data_out,
    input  logic [1:0]            alu_resp_in,
    input  logic [31:0]           alu_data_in,
    output logic                  timeout_err
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 1 || NUM_REQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
        $error("calc1_port_arbiter: NUM_REQ must be 1..8 and TIMEOUT >= 2");
    end

    typedef enum logic [2:0] {A_IDLE, A_OP1, A_OP2, A_WAIT, A_RESP} arb_st_t;

    logic [NUM_REQ-1:0]        slot_pend;
    logic [NUM_REQ-1:0]        slot_done;
    logic [NUM_REQ-1:0][3:0]   slot_cmd;
    logic [NUM_REQ-1:0][31:0]  slot_op1;
    logic [NUM_REQ-1:0][31:0]  slot_op2;

    arb_st_t                   arb_q, arb_d;
    logic [GW-1:0]             grant_q, grant_d;
    logic [GW-1:0]             last_q, last_d;
    logic [3:0]                alu_cmd_q, alu_cmd_d;
    logic [31:0]               alu_data_q, alu_data_d;
    logic [NUM_REQ-1:0][1:0]   out_resp_q, out_resp_d;
    logic [NUM_REQ-1:0][31:0]  out_data_q, out_data_d;

    logic                      found;
    logic [GW-1:0]             grant_nxt;
    logic [GW-1:0]             idx_w;
    int                        idx;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        calc1_arb_slot u_slot (
            .c_clk   (c_clk),
            .reset   (reset),
            .cmd_in  (req_cmd_in[4*i +: 4]),
            .data_in (req_data_in[32*i +: 32]),
            .done    (slot_done[i]),
            .busy    (req_busy[i]),
            .pend    (slot_pend[i]),
            .cmd     (slot_cmd[i]),
            .op1     (slot_op1[i]),
            .op2     (slot_op2[i])
        );
        assign slot_done[i] = (arb_q == A_RESP) && (grant_q == GW'(i));
    end

    // Round-robin pick: first pending slot after the last one served.
    always_comb begin
        found     = 1'b0;
        grant_nxt = '0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_w = GW'(idx);
            if (!found && slot_pend[idx_w]) begin
                found     = 1'b1;
                grant_nxt = idx_w;
            end
        end
    end

`ifdef CALC1_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] timer_q, timer_d;
    logic          tmo_q, tmo_d;
`endif

    // Arbiter next-state; ALU drive and per-slot responses are registered.
    always_comb begin
        arb_d      = arb_q;
        grant_d    = grant_q;
        last_d     = last_q;
        alu_cmd_d  = 4'b0000;
        alu_data_d = 32'd0;
        out_resp_d = '0;
        out_data_d = '0;
`ifdef CALC1_ARB_TIMEOUT_EN
        timer_d    = timer_q;
        tmo_d      = 1'b0;
`endif
        case (arb_q)
            A_IDLE: begin
                if (found) begin
                    grant_d    = grant_nxt;
                    alu_cmd_d  = slot_cmd[grant_nxt];
                    alu_data_d = slot_op1[grant_nxt];
                    arb_d      = A_OP1;
                end
            end
            A_OP1: begin
                alu_data_d = slot_op2[grant_q];
                arb_d      = A_OP2;
            end
            A_OP2: begin
`ifdef CALC1_ARB_TIMEOUT_EN
                timer_d = '0;
`endif
                arb_d = A_WAIT;
            end
            A_WAIT: begin
                if (alu_resp_in != 2'b00) begin
                    out_resp_d[grant_q] = alu_resp_in;
                    out_data_d[grant_q] = alu_data_in;
                    arb_d               = A_RESP;
                end
`ifdef CALC1_ARB_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT - 1)) begin
                    // ALU never answered: report invalid/timeout to the owner
                    out_resp_d[grant_q] = 2'b11;
                    out_data_d[grant_q] = 32'd0;
                    tmo_d               = 1'b1;
                    arb_d               = A_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
`endif
            end
            A_RESP: begin
                last_d = grant_q;
                arb_d  = A_IDLE;
            end
            default: arb_d = A_IDLE;
        endcase
    end

    // Arbiter state and registered outputs.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            arb_q      <= A_IDLE;
            grant_q    <= '0;
            last_q     <= GW'(NUM_REQ - 1);
            alu_cmd_q  <= 4'b0000;
            alu_data_q <= 32'd0;
            out_resp_q <= '0;
            out_data_q <= '0;
        end else begin
            arb_q      <= arb_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            alu_cmd_q  <= alu_cmd_d;
            alu_data_q <= alu_data_d;
            out_resp_q <= out_resp_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef CALC1_ARB_TIMEOUT_EN
    // Watchdog counter and expiry pulse.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            timer_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            tmo_q   <= tmo_d;
        end
    end
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign alu_cmd_out  = alu_cmd_q;
    assign alu_data_out = alu_data_q;
    assign out_resp     = out_resp_q;
    assign out_data     = out_data_q;
endmodule

// File: tb/tb_calc1_port_arbiter.sv
// Directed bench for calc1_port_arbiter with a behavioural calc1 ALU model.
`timescale 1ns/1ps
module tb_calc1_port_arbiter;
    localparam int NR = 4;
    localparam int TO = 16;

    logic              c_clk = 1'b0;
    logic              reset = 1'b1;
    logic [4*NR-1:0]   req_cmd_in = '0;
    logic [32*NR-1:0]  req_data_in = '0;
    logic [2*NR-1:0]   out_resp;
    logic [32*NR-1:0]  out_data;
    logic [NR-1:0]     req_busy;
    logic [3:0]        alu_cmd_out;
    logic [31:0]       alu_data_out;
    logic [1:0]        alu_resp_in;
    logic [31:0]       alu_data_in;
    logic              timeout_err;

    calc1_port_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .c_clk(c_clk), .reset(reset),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .out_resp(out_resp), .out_data(out_data), .req_busy(req_busy),
        .alu_cmd_out(alu_cmd_out), .alu_data_out(alu_data_out),
        .alu_resp_in(alu_resp_in), .alu_data_in(alu_data_in),
        .timeout_err(timeout_err)
    );

    always #5 c_clk = ~c_clk;

    int cyc = 0;
    always @(posedge c_clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // ---------------- response monitor ----------------
    int          rcnt[NR];
    logic [1:0]  rresp[NR];
    logic [31:0] rdata[NR];
    int          rcyc[NR];
    int          bfall[NR];
    int          stray = 0;
    int          tcnt = 0;
    int          tcyc = 0;
    logic [NR-1:0] busy_prev = '0;

    always @(negedge c_clk) begin
        for (int i = 0; i < NR; i++) begin
            if (out_resp[2*i +: 2] != 2'b00) begin
                rcnt[i]  <= rcnt[i] + 1;
                rresp[i] <= out_resp[2*i +: 2];
                rdata[i] <= out_data[32*i +: 32];
                rcyc[i]  <= cyc;
            end else if (out_data[32*i +: 32] != 32'd0) begin
                stray <= stray + 1;
            end
            if (busy_prev[i] && !req_busy[i]) bfall[i] <= cyc;
        end
        busy_prev <= req_busy;
        if (timeout_err === 1'b1) begin
            tcnt <= tcnt + 1;
            tcyc <= cyc;
        end
    end

    // ---------------- calc1 ALU model ----------------
    int          alu_mode = 0;   // 0 answer, 1 silent, 2 answer late after a reset
    int          alu_wait = 0;   // extra wait cycles before answering
    logic [31:0] m_cmd[$];
    logic [31:0] m_a[$];
    logic [31:0] m_b[$];
    logic [31:0] m_mid[$];
    logic [31:0] m_cyc[$];

    function automatic void alu_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                     output logic [1:0] r, output logic [31:0] d);
        logic [32:0] s;
        r = 2'b11;
        d = 32'd0;
        case (c)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                if (s[32]) r = 2'b10;
                else begin r = 2'b01; d = s[31:0]; end
            end
            4'd2: begin
                if (b > a) r = 2'b10;
                else begin r = 2'b01; d = a - b; end
            end
            default: ;
        endcase
    endfunction

    initial begin : alu_model
        logic [3:0]  c;
        logic [31:0] a, b, d;
        logic [1:0]  r;
        alu_resp_in = 2'b00;
        alu_data_in = 32'd0;
        forever begin
            @(negedge c_clk);
            if (!reset && alu_cmd_out != 4'b0000) begin
                c = alu_cmd_out;
                a = alu_data_out;
                m_cyc.push_back(cyc);
                @(negedge c_clk);
                b = alu_data_out;
                m_mid.push_back({28'd0, alu_cmd_out});
                m_cmd.push_back({28'd0, c});
                m_a.push_back(a);
                m_b.push_back(b);
                alu_calc(c, a, b, r, d);
                if (alu_mode == 0) begin
                    @(posedge c_clk);
                    repeat (alu_wait) @(posedge c_clk);
                    #1 alu_resp_in = r; alu_data_in = d;
                    @(posedge c_clk);
                    #1 alu_resp_in = 2'b00; alu_data_in = 32'd0;
                end else if (alu_mode == 2) begin
                    wait (reset == 1'b1);
                    wait (reset == 1'b0);
                    repeat (2) @(posedge c_clk);
                    #1 alu_resp_in = 2'b01; alu_data_in = 32'd2;
                    @(posedge c_clk);
                    #1 alu_resp_in = 2'b00; alu_data_in = 32'd0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [4*NR-1:0] cvec(input int s, input logic [3:0] c);
        logic [4*NR-1:0] v;
        v = '0;
        v[4*s +: 4] = c;
        return v;
    endfunction

    function automatic logic [32*NR-1:0] dvec(input int s, input logic [31:0] d);
        logic [32*NR-1:0] v;
        v = '0;
        v[32*s +: 32] = d;
        return v;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic drive(input logic [4*NR-1:0] c, input logic [32*NR-1:0] d1,
                         input logic [32*NR-1:0] d2, output int j);
        @(posedge c_clk); #1;
        j = cyc;
        req_cmd_in  = c;
        req_data_in = d1;
        @(posedge c_clk); #1;
        req_cmd_in  = '0;
        req_data_in = d2;
        @(posedge c_clk); #1;
        req_data_in = '0;
    endtask

    task automatic drain(input string tag, input int bound);
        int n;
        n = 0;
        while (req_busy != '0 && n < bound) begin
            @(negedge c_clk);
            n++;
        end
        @(posedge c_clk); #1;
        chk(tag, {60'd0, req_busy}, 64'd0);
    endtask

    task automatic do_reset();
        @(posedge c_clk); #1 reset = 1'b1;
        repeat (2) @(posedge c_clk);
        #1 reset = 1'b0;
    endtask

    function automatic int rsum(input int a[NR]);
        int s;
        s = 0;
        for (int i = 0; i < NR; i++) s += a[i];
        return s;
    endfunction

    // ---------------- directed tests ----------------
    initial begin : main
        int j, j2, n0;
        int rc0[NR];
        int tc0;

        repeat (3) @(posedge c_clk);
        #1 reset = 1'b0;
        @(negedge c_clk);
        chk("rst_resp",    {56'd0, out_resp}, 64'd0);
        chk("rst_data",    {63'd0, (out_data != '0)}, 64'd0);
        chk("rst_busy",    {60'd0, req_busy}, 64'd0);
        chk("rst_alu_cmd", {60'd0, alu_cmd_out}, 64'd0);
        chk("rst_alu_dat", {32'd0, alu_data_out}, 64'd0);
        chk("rst_tmo",     {63'd0, timeout_err}, 64'd0);

        // Single SUB 10-3 on slot 0, ALU answers after 2 extra wait cycles.
        rc0 = rcnt; n0 = m_cmd.size();
        alu_mode = 0; alu_wait = 2;
        drive(cvec(0, 4'd2), dvec(0, 32'd10), dvec(0, 32'd3), j);
        drain("t1_drain", 40);
        chk("t1_ntxn",     m_cmd.size() - n0, 1);
        chk("t1_alu_cmd",  qget(m_cmd, n0), 2);
        chk("t1_alu_op1",  qget(m_a, n0), 10);
        chk("t1_alu_op2",  qget(m_b, n0), 3);
        chk("t1_op2_cmd0", qget(m_mid, n0), 0);
        chk("t1_cmd_cyc",  qget(m_cyc, n0), j + 3);
        chk("t1_nresp",    rcnt[0] - rc0[0], 1);
        chk("t1_resp",     rresp[0], 1);
        chk("t1_data",     rdata[0], 7);
        chk("t1_resp_cyc", rcyc[0], j + 8);
        chk("t1_busy_cyc", bfall[0], j + 9);
        chk("t1_others",   (rsum(rcnt) - rcnt[0]) - (rsum(rc0) - rc0[0]), 0);

        // Four simultaneous ADDs right after reset: served 0,1,2,3.
        do_reset();
        rc0 = rcnt; n0 = m_cmd.size();
        alu_wait = 0;
        drive({4'd1, 4'd1, 4'd1, 4'd1}, {32'd4, 32'd3, 32'd2, 32'd1},
              {32'd100, 32'd100, 32'd100, 32'd100}, j);
        drain("t2_drain", 80);
        chk("t2_ntxn",    m_cmd.size() - n0, 4);
        chk("t2_first",   qget(m_cyc, n0), j + 3);
        chk("t2_spacing", qget(m_cyc, n0 + 1) - qget(m_cyc, n0), 5);
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("t2_order%0d", i), qget(m_a, n0 + i), i + 1);
            chk($sformatf("t2_nresp%0d", i), rcnt[i] - rc0[i], 1);
            chk($sformatf("t2_resp%0d", i),  rresp[i], 1);
            chk($sformatf("t2_data%0d", i),  rdata[i], 101 + i);
        end

        // Underflow on slot 2 is forwarded as 10.
        rc0 = rcnt;
        alu_wait = 1;
        drive(cvec(2, 4'd2), dvec(2, 32'd3), dvec(2, 32'd10), j);
        drain("t3_drain", 40);
        chk("t3_nresp",  rcnt[2] - rc0[2], 1);
        chk("t3_resp",   rresp[2], 2);
        chk("t3_data",   rdata[2], 0);
        chk("t3_others", (rsum(rcnt) - rcnt[2]) - (rsum(rc0) - rc0[2]), 0);

        // Second command on a busy slot is dropped.
        rc0 = rcnt; n0 = m_cmd.size();
        drive(cvec(1, 4'd1), dvec(1, 32'd5), dvec(1, 32'd6), j);
        drive(cvec(1, 4'd1), dvec(1, 32'd50), dvec(1, 32'd60), j2);
        drain("t4_drain", 40);
        repeat (4) @(posedge c_clk);
        #1;
        chk("t4_ntxn",  m_cmd.size() - n0, 1);
        chk("t4_op1",   qget(m_a, n0), 5);
        chk("t4_nresp", rcnt[1] - rc0[1], 1);
        chk("t4_data",  rdata[1], 11);

        // Reset while waiting on the ALU; its late answer must be ignored.
        rc0 = rcnt;
        alu_mode = 2;
        drive(cvec(3, 4'd1), dvec(3, 32'd1), dvec(3, 32'd1), j);
        repeat (3) @(posedge c_clk);
        #1 reset = 1'b1;
        @(posedge c_clk);
        #1 reset = 1'b0;
        repeat (8) @(negedge c_clk);
        chk("t5_nresp",   rsum(rcnt) - rsum(rc0), 0);
        chk("t5_busy",    {60'd0, req_busy}, 64'd0);
        chk("t5_alu_cmd", {60'd0, alu_cmd_out}, 64'd0);
        chk("t5_resp",    {56'd0, out_resp}, 64'd0);
        alu_mode = 0;

`ifdef CALC1_ARB_TIMEOUT_EN
        // Silent ALU: watchdog answers 11 after TIMEOUT wait cycles.
        rc0 = rcnt; tc0 = tcnt;
        alu_mode = 1;
        drive(cvec(0, 4'd1), dvec(0, 32'd7), dvec(0, 32'd8), j);
        drain("t6_drain", 60);
        chk("t6_nresp",    rcnt[0] - rc0[0], 1);
        chk("t6_resp",     rresp[0], 3);
        chk("t6_data",     rdata[0], 0);
        chk("t6_resp_cyc", rcyc[0], j + 6 + TO - 1);
        chk("t6_ntmo",     tcnt - tc0, 1);
        chk("t6_tmo_cyc",  tcyc, rcyc[0]);
        alu_mode = 0;
        drive(cvec(0, 4'd1), dvec(0, 32'd7), dvec(0, 32'd8), j);
        drain("t6b_drain", 40);
        chk("t6b_resp", rresp[0], 1);
        chk("t6b_data", rdata[0], 15);
`else
        tc0 = 0;
        chk("tmo_tied", tcnt - tc0, 0);
`endif

        chk("stray_data", stray, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "bench watchdog expired");
    end
endmodule
